// File: rtl/axis_sink.sv
// AXI-Stream sink that checks an incrementing data pattern, applies a rotating TREADY
// backpressure mask, and watches for protocol violations and stalls.
module axis_sink #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned COUNT      = 32,
  parameter logic [7:0]  READY_MASK = 8'b1111_1111,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             done,
  output logic                             pass,
  output logic                             data_err,
  output logic                             proto_err,
  output logic                             timeout_err,
  output logic [$clog2(COUNT+1)-1:0]       err_count,
  output logic [$clog2(COUNT+1)-1:0]       first_err_idx,
  output logic [$clog2(COUNT+1)-1:0]       rx_count,
  input  logic                             S_AXIS_TVALID,
  input  logic [DATA_WIDTH-1:0]            S_AXIS_TDATA,
  output logic                             S_AXIS_TREADY
);

  localparam int unsigned CntW   = $clog2(COUNT + 1);
  localparam int unsigned StallW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StRecv, StDone} state_e;

  state_e                state_q, state_d;
  logic                  tready_q, tready_d;
  logic [2:0]            phase_q, phase_d;
  logic [DATA_WIDTH-1:0] expected_q, expected_d;
  logic [CntW-1:0]       rx_count_q, rx_count_d;
  logic [CntW-1:0]       err_count_q, err_count_d;
  logic [CntW-1:0]       first_err_idx_q, first_err_idx_d;
  logic                  data_err_q, data_err_d;
  logic                  proto_err_q, proto_err_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [StallW-1:0]     stall_q, stall_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
  logic                  hs;
  logic                  finish;

  assign hs = (state_q == StRecv) && S_AXIS_TVALID && tready_q;

  always_comb begin
    state_d         = state_q;
    tready_d        = tready_q;
    phase_d         = phase_q;
    expected_d      = expected_q;
    rx_count_d      = rx_count_q;
    err_count_d     = err_count_q;
    first_err_idx_d = first_err_idx_q;
    data_err_d      = data_err_q;
    proto_err_d     = proto_err_q;
    timeout_err_d   = timeout_err_q;
    done_d          = 1'b0;
    pass_d          = pass_q;
    stall_d         = stall_q;
    pend_d          = pend_q;
    pend_data_d     = pend_data_q;
    finish          = 1'b0;

    unique case (state_q)
      StIdle: begin
        tready_d = 1'b0;
        if (start) begin
          state_d         = StRecv;
          tready_d        = READY_MASK[0];
          phase_d         = 3'd0;
          expected_d      = '0;
          rx_count_d      = '0;
          err_count_d     = '0;
          first_err_idx_d = '0;
          data_err_d      = 1'b0;
          proto_err_d     = 1'b0;
          timeout_err_d   = 1'b0;
          pass_d          = 1'b0;
          stall_d         = '0;
          pend_d          = 1'b0;
          pend_data_d     = '0;
        end
      end

      StRecv: begin
        // Phase advances every cycle; TREADY for the next cycle comes from the new phase.
        phase_d     = phase_q + 3'd1;
        tready_d    = READY_MASK[phase_d];
        pend_d      = S_AXIS_TVALID & ~tready_q;
        pend_data_d = S_AXIS_TDATA;

        if (pend_q && (!S_AXIS_TVALID || (S_AXIS_TDATA != pend_data_q))) begin
          proto_err_d = 1'b1;
        end

        if (hs) begin
          if (S_AXIS_TDATA != expected_q) begin
            data_err_d  = 1'b1;
            err_count_d = err_count_q + CntW'(1);
            if (!data_err_q) begin
              first_err_idx_d = rx_count_q;
            end
          end
          expected_d = expected_q + DATA_WIDTH'(1);
          rx_count_d = rx_count_q + CntW'(1);
          stall_d    = '0;
          if (rx_count_q == CntW'(COUNT - 1)) begin
            finish = 1'b1;
          end
        end else begin
          stall_d = stall_q + StallW'(1);
          if (stall_q == StallW'(TIMEOUT - 1)) begin
            timeout_err_d = 1'b1;
            finish        = 1'b1;
          end
        end

        if (finish) begin
          tready_d = 1'b0;
          state_d  = StDone;
          done_d   = 1'b1;
          pass_d   = (rx_count_d == CntW'(COUNT)) && !data_err_d && !proto_err_d &&
                     !timeout_err_d;
        end
      end

      StDone: begin
        tready_d = 1'b0;
        state_d  = StIdle;
      end

      default: begin
        tready_d = 1'b0;
        state_d  = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      tready_q        <= 1'b0;
      phase_q         <= 3'd0;
      expected_q      <= '0;
      rx_count_q      <= '0;
      err_count_q     <= '0;
      first_err_idx_q <= '0;
      data_err_q      <= 1'b0;
      proto_err_q     <= 1'b0;
      timeout_err_q   <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      stall_q         <= '0;
      pend_q          <= 1'b0;
      pend_data_q     <= '0;
    end else begin
      state_q         <= state_d;
      tready_q        <= tready_d;
      phase_q         <= phase_d;
      expected_q      <= expected_d;
      rx_count_q      <= rx_count_d;
      err_count_q     <= err_count_d;
      first_err_idx_q <= first_err_idx_d;
      data_err_q      <= data_err_d;
      proto_err_q     <= proto_err_d;
      timeout_err_q   <= timeout_err_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      stall_q         <= stall_d;
      pend_q          <= pend_d;
      pend_data_q     <= pend_data_d;
    end
  end

  assign done          = done_q;
  assign pass          = pass_q;
  assign data_err      = data_err_q;
  assign proto_err     = proto_err_q;
  assign timeout_err   = timeout_err_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;
  assign rx_count      = rx_count_q;
  assign S_AXIS_TREADY = tready_q;

endmodule
